// File: rtl/chan_packet_pkg.sv
// chan_packet shared definitions: command/status bit positions
// and the coefficient loader state encoding.
package chan_packet_pkg;

  localparam int CMD_LOAD   = 31;
  localparam int CMD_COMMIT = 30;
  localparam int CMD_CLR    = 29;

  // The pair index is read from a 16-bit field so that
  // out-of-range software values are still visible to the checker.
  localparam int IDX_W = 16;

  localparam int ST_BUSY = 31;
  localparam int ST_PEND = 30;
  localparam int ST_OVR  = 29;
  localparam int ST_RNG  = 28;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_EVEN = 2'd1,
    WR_ODD  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/toggle_edge_det.sv
// Per-bit toggle reference with priming: the first cycle after reset
// adopts the current levels so stale software toggles never fire.
module toggle_edge_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] pulse
);

  logic         prime;
  logic [W-1:0] ref_q;

  assign pulse = prime ? '0 : (d ^ ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= 1'b1;
      ref_q <= '0;
    end else begin
      prime <= 1'b0;
      ref_q <= d;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: writes tap pairs into the shadow bank and
// swaps banks on a frame boundary after a software commit.
module fir_coef_loader
  import chan_packet_pkg::*;
#(
  parameter int TAP_W  = 16,
  parameter int N_TAPS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       coef_in,
  input  logic [31:0]       cmd_in,
  input  logic              fir_sync,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [TAP_W-1:0]  coef_data,
  output logic              bank_swap,
  output logic              active_bank,
  output logic [31:0]       status_out
);

  localparam int N_PAIRS = N_TAPS / 2;

  logic [31:0]         cmd_q;
  logic [31:0]         coef_q;
  logic [2:0]          edge_p;
  logic                load_e;
  logic                commit_e;
  logic                clr_e;
  logic [IDX_W-1:0]    idx_raw;
  logic                in_range;
  logic                busy;
  logic                take;
  logic                fire;
  logic                ovr_set;
  logic                rng_set;
  ld_state_e           state_q;
  ld_state_e           state_d;
  logic [ADDR_W-2:0]   pair_q;
  logic [2*TAP_W-1:0]  pair_w_q;
  logic                pend_q;
  logic                ovr_q;
  logic                rng_q;
  logic                swap_q;
  logic                act_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                unused_cmd;

  // Software registers are already synchronous; sample every cycle,
  // reset included, so priming sees the live levels.
  always_ff @(posedge user_clk) begin
    cmd_q  <= cmd_in;
    coef_q <= coef_in;
  end

  toggle_edge_det #(
    .W(3)
  ) u_edge (
    .clk  (user_clk),
    .rst_n(user_rst_n),
    .d    (cmd_q[CMD_LOAD:CMD_CLR]),
    .pulse(edge_p)
  );

  assign load_e   = edge_p[2];
  assign commit_e = edge_p[1];
  assign clr_e    = edge_p[0];
  assign idx_raw  = cmd_q[IDX_W-1:0];
  assign in_range = idx_raw < IDX_W'(N_PAIRS);
  assign busy     = state_q != IDLE;
  assign ovr_set  = load_e && busy;
  assign rng_set  = load_e && !busy && !in_range;
  assign fire     = fir_sync && pend_q && !busy;

  assign unused_cmd = ^cmd_q[CMD_CLR-1:IDX_W];

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    unique case (state_q)
      IDLE: begin
        if (load_e && in_range) begin
          state_d = WR_EVEN;
          take    = 1'b1;
        end
      end
      WR_EVEN: begin
        coef_we   = 1'b1;
        coef_addr = {pair_q, 1'b0};
        coef_data = pair_w_q[2*TAP_W-1:TAP_W];
        state_d   = WR_ODD;
      end
      WR_ODD: begin
        coef_we   = 1'b1;
        coef_addr = {pair_q, 1'b1};
        coef_data = pair_w_q[TAP_W-1:0];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= IDLE;
      pair_q   <= '0;
      pair_w_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        pair_q   <= idx_raw[ADDR_W-2:0];
        pair_w_q <= coef_q[2*TAP_W-1:0];
      end
      if (state_q == WR_ODD)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A new error outranks a clear landing in the same cycle.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ovr_q  <= 1'b0;
      rng_q  <= 1'b0;
      pend_q <= 1'b0;
      swap_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      if (ovr_set)    ovr_q <= 1'b1;
      else if (clr_e) ovr_q <= 1'b0;
      if (rng_set)    rng_q <= 1'b1;
      else if (clr_e) rng_q <= 1'b0;
      if (commit_e)   pend_q <= 1'b1;
      else if (fire)  pend_q <= 1'b0;
      swap_q <= fire;
      act_q  <= act_q ^ fire;
    end
  end

  assign bank_swap   = swap_q;
  assign active_bank = act_q;

  always_comb begin
    status_out            = '0;
    status_out[ST_BUSY]   = busy;
    status_out[ST_PEND]   = pend_q;
    status_out[ST_OVR]    = ovr_q;
    status_out[ST_RNG]    = rng_q;
    status_out[CNT_W-1:0] = cnt_q;
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: cycle-indexed expectation tables filled
// from the command rules, plus literal spot checks.
module tb_fir_coef_loader;

  localparam int NCYC = 512;
  localparam int F_PEND = 0;
  localparam int F_OVR  = 1;
  localparam int F_RNG  = 2;
  localparam int F_ACT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] coef_in;
  logic [31:0] cmd_in;
  logic        fir_sync;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        bank_swap;
  logic        active_bank;
  logic [31:0] status_out;

  fir_coef_loader dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .coef_in    (coef_in),
    .cmd_in     (cmd_in),
    .fir_sync   (fir_sync),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .bank_swap  (bank_swap),
    .active_bank(active_bank),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit        pend;
    bit        ovr;
    bit        rng;
    bit        act;
    bit [15:0] cnt;
  } ms_t;

  ms_t     m  [NCYC];
  bit      ew [NCYC];
  int      ea [NCYC];
  int      ed [NCYC];
  bit      es [NCYC];
  bit [2:0] prev;
  bit      primed = 1'b0;
  int      last_commit_d = -10;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fill(input int f, input int from, input bit v);
    for (int x = from; x < NCYC; x++)
      case (f)
        F_PEND:  m[x].pend = v;
        F_OVR:   m[x].ovr  = v;
        F_RNG:   m[x].rng  = v;
        default: m[x].act  = v;
      endcase
  endtask

  task automatic mwrite(input int x, input int a, input int dv);
    if (x < NCYC) begin
      ew[x] = 1'b1;
      ea[x] = a;
      ed[x] = dv;
    end
  endtask

  // Compare cycle c, then fold this cycle's inputs into the tables.
  always @(negedge clk) begin
    int c;
    int d;
    int idx;
    bit [2:0] tog;
    logic [31:0] st;
    c = cyc;
    if (chk_on && c < NCYC - 4) begin
      st = {ew[c], m[c].pend, m[c].ovr, m[c].rng, 12'h000, m[c].cnt};
      chk("coef_we", coef_we, ew[c]);
      if (ew[c]) begin
        chk("coef_addr", coef_addr, ea[c]);
        chk("coef_data", coef_data, ed[c]);
      end
      chk("bank_swap", bank_swap, es[c]);
      chk("active_bank", active_bank, m[c].act);
      chk("status_out", status_out, st);
      if (!rst_n) begin
        primed = 1'b0;
      end else if (!primed) begin
        prev   = cmd_in[31:29];
        primed = 1'b1;
      end else begin
        d   = c + 1;
        tog = cmd_in[31:29] ^ prev;
        prev = cmd_in[31:29];
        idx = int'(cmd_in[15:0]);
        if (fir_sync && m[c].pend && !ew[c]) begin
          es[c+1] = 1'b1;
          fill(F_ACT, c + 1, !m[c].act);
          if (last_commit_d != c) fill(F_PEND, c + 1, 1'b0);
        end
        if (tog[0]) begin
          fill(F_OVR, d + 1, 1'b0);
          fill(F_RNG, d + 1, 1'b0);
        end
        if (tog[2]) begin
          if (ew[d]) begin
            fill(F_OVR, d + 1, 1'b1);
          end else if (idx >= 16) begin
            fill(F_RNG, d + 1, 1'b1);
          end else begin
            mwrite(d + 1, 2 * idx, int'(coef_in[31:16]));
            mwrite(d + 2, 2 * idx + 1, int'(coef_in[15:0]));
            for (int x = d + 3; x < NCYC; x++) m[x].cnt++;
          end
        end
        if (tog[1]) begin
          fill(F_PEND, d + 1, 1'b1);
          last_commit_d = d;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int idx);
    cmd_in[31]   = ~cmd_in[31];
    cmd_in[15:0] = idx[15:0];
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) m[i] = '0;
    rst_n    = 1'b0;
    cmd_in   = 32'h8000_0000;
    coef_in  = 32'h0;
    fir_sync = 1'b0;
    chk_on   = 1'b1;
    repeat (4) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("reset_status", status_out, 32'h0);

    coef_in = 32'h1234_ABCD;
    step();
    do_load(3);
    step();
    step();
    chk("even_we", coef_we, 1);
    chk("even_addr", coef_addr, 6);
    chk("even_data", coef_data, 16'h1234);
    step();
    chk("odd_addr", coef_addr, 7);
    chk("odd_data", coef_data, 16'hABCD);
    step();
    chk("count_one", status_out[15:0], 1);

    step();
    do_load(16);
    repeat (3) step();
    chk("range_set", status_out[28], 1);
    cmd_in[29] = ~cmd_in[29];
    repeat (3) step();
    chk("range_clr", status_out[28], 0);

    coef_in = 32'h5555_AAAA;
    step();
    do_load(5);
    step();
    step();
    coef_in = 32'h0F0F_F0F0;
    do_load(6);
    repeat (4) step();
    chk("overrun_set", status_out[29], 1);
    chk("count_two", status_out[15:0], 2);

    cmd_in[30] = ~cmd_in[30];
    repeat (10) step();
    fir_sync = 1'b1;
    chk("pend_before", status_out[30], 1);
    step();
    fir_sync = 1'b0;
    chk("swap_pulse", bank_swap, 1);
    chk("bank_one", active_bank, 1);
    chk("pend_after", status_out[30], 0);
    step();
    chk("swap_single", bank_swap, 0);

    coef_in = 32'hCAFE_BEEF;
    step();
    do_load(2);
    cmd_in[30] = ~cmd_in[30];
    repeat (3) step();
    fir_sync = 1'b1;
    chk("busy_at_sync", status_out[31], 1);
    step();
    fir_sync = 1'b0;
    chk("no_swap_busy", bank_swap, 0);
    repeat (16) step();
    fir_sync = 1'b1;
    step();
    fir_sync = 1'b0;
    chk("deferred_swap", bank_swap, 1);
    chk("bank_zero", active_bank, 0);

    step();
    cmd_in[30] = ~cmd_in[30];
    step();
    fir_sync = 1'b1;
    step();
    fir_sync = 1'b0;
    chk("same_cyc_noswap", bank_swap, 0);
    chk("same_cyc_pend", status_out[30], 1);
    repeat (5) step();
    fir_sync = 1'b1;
    step();
    fir_sync = 1'b0;
    chk("later_swap", bank_swap, 1);

    step();
    cmd_in[29] = ~cmd_in[29];
    repeat (3) step();
    chk("overrun_clr", status_out[29], 0);
    do_load(7);
    step();
    cmd_in[29] = ~cmd_in[29];
    do_load(8);
    repeat (4) step();
    chk("error_wins", status_out[29], 1);

    repeat (4) step();
    do_load(1);
    step();
    step();
    chk("mid_write_we", coef_we, 1);
    chk_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", coef_we, 0);
    chk("async_status", status_out, 32'h0);
    chk("async_bank", active_bank, 0);
    #20;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
